// File: rtl/fifo.sv
// Single-clock FIFO with a first-word-fall-through read port and non-power-of-two depth.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_valid,
    input  logic             r_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             fifo_full,
    output logic             fifo_empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_accept;
    logic             rd_accept;

    // Pointers wrap explicitly at DEPTH-1 so any depth works, not only powers of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign wr_accept  = w_valid && !fifo_full;
    assign rd_accept  = r_ready && !fifo_empty;
    assign data_out   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_accept) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky until reset so a slow supervisor can still see a single dropped access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_valid && fifo_full) begin
                overflow <= 1'b1;
            end
            if (r_ready && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo.sv
// Randomized self-checking bench for fifo against a queue-based reference model.
// Honors FIFO_ERR_FLAGS_EN to also check the sticky error flags.
module tb_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;

    logic             clk;
    logic             reset;
    logic             w_valid;
    logic             r_ready;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             fifo_full;
    logic             fifo_empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic             overflow;
    logic             underflow;
`endif

    logic [WIDTH-1:0] model_q[$];
    logic             model_ovf;
    logic             model_unf;
    int               checks;
    int               failures;

    fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .w_valid   (w_valid),
        .r_ready   (r_ready),
        .data_in   (data_in),
        .data_out  (data_out),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compare visible outputs with the model before the edge, then apply the edge.
    task automatic applyStimulus(input logic w, input logic r, input logic [WIDTH-1:0] d);
        logic wr_ok;
        logic rd_ok;
        w_valid = w;
        r_ready = r;
        data_in = d;
        checkOutput("empty", {31'b0, fifo_empty}, {31'b0, model_q.size() == 0});
        checkOutput("full", {31'b0, fifo_full}, {31'b0, model_q.size() == DEPTH});
        if (model_q.size() > 0) begin
            checkOutput("data_out", data_out, model_q[0]);
        end
`ifdef FIFO_ERR_FLAGS_EN
        checkOutput("overflow", {31'b0, overflow}, {31'b0, model_ovf});
        checkOutput("underflow", {31'b0, underflow}, {31'b0, model_unf});
`endif
        wr_ok = w && (model_q.size() < DEPTH);
        rd_ok = r && (model_q.size() > 0);
        if (w && model_q.size() == DEPTH) model_ovf = 1'b1;
        if (r && model_q.size() == 0) model_unf = 1'b1;
        @(posedge clk);
        if (rd_ok) void'(model_q.pop_front());
        if (wr_ok) model_q.push_back(d);
        #1;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic doReset();
        w_valid = 1'b0;
        r_ready = 1'b0;
        reset   = 1'b0;
        #2;
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        checkOutput("rst_empty", {31'b0, fifo_empty}, 32'd1);
        checkOutput("rst_full", {31'b0, fifo_full}, 32'd0);
        checkOutput("rst_data", data_out, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic drainAll();
        for (int k = 0; k < 2 * DEPTH && model_q.size() > 0; k++) begin
            applyStimulus(1'b0, 1'b1, '0);
        end
        checkOutput("drained", {31'b0, fifo_empty}, 32'd1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        model_ovf = 1'b0;
        model_unf = 1'b0;
        w_valid   = 1'b0;
        r_ready   = 1'b0;
        data_in   = '0;
        reset     = 1'b0;
        #1;
        doReset();

        // Fill, then one dropped write while full
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, WIDTH'(i));
        end
        checkOutput("full_after_fill", {31'b0, fifo_full}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'd3);
        checkOutput("full_held", {31'b0, fifo_full}, 32'd1);

        // Drain in order; value 3 must never show up
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("drain_order", data_out, WIDTH'(i));
            applyStimulus(1'b0, 1'b1, '0);
        end
        checkOutput("empty_after_drain", {31'b0, fifo_empty}, 32'd1);

        // Streaming with concurrent reads
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 1'b1, WIDTH'(i));
        end
        drainAll();

        // Read+write while full: only the pop happens
        applyStimulus(1'b1, 1'b0, 32'd10);
        applyStimulus(1'b1, 1'b0, 32'd11);
        applyStimulus(1'b1, 1'b0, 32'd12);
        applyStimulus(1'b1, 1'b1, 32'd13);
        checkOutput("full_rw_full", {31'b0, fifo_full}, 32'd0);
        checkOutput("full_rw_data", data_out, 32'd11);
        drainAll();

        // Read+write while empty: only the write happens
        applyStimulus(1'b1, 1'b1, 32'd20);
        checkOutput("empty_rw_empty", {31'b0, fifo_empty}, 32'd0);
        checkOutput("empty_rw_full", {31'b0, fifo_full}, 32'd0);
        checkOutput("empty_rw_data", data_out, 32'd20);
        drainAll();

        // Random bursts with one mid-burst reset pulse
        for (int b = 0; b < 600; b++) begin
            int len;
            int w_pct;
            int r_pct;
            len   = $urandom_range(1, 6);
            w_pct = $urandom_range(0, 100);
            r_pct = $urandom_range(0, 100);
            for (int c = 0; c < len; c++) begin
                if (b == 300 && c == len / 2) begin
                    doReset();
                    checkOutput("mid_reset_empty", {31'b0, fifo_empty}, 32'd1);
                end
                applyStimulus($urandom_range(0, 99) < w_pct, $urandom_range(0, 99) < r_pct,
                              $urandom);
            end
        end
        drainAll();

        $display("%0d/%0d checks passed", checks - failures, checks);
        $finish;
    end

endmodule
